// File: rtl/shared_bv_pkg.sv
// Shared types and defaults for the masked bitvector join controller.
// Holds the sequencing state enum and half/full shared-vector typedefs.
`timescale 1ns/1ps
package shared_bv_pkg;

  localparam int NUM_SHARES_DEF = 2;
  localparam int HALF_WIDTH_DEF = 15;
  localparam int BIT_WIDTH_DEF  = 2 * HALF_WIDTH_DEF;

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    FULL    = 2'd2
  } join_state_e;

  typedef logic [NUM_SHARES_DEF-1:0][HALF_WIDTH_DEF-1:0] half_sv_t;
  typedef logic [NUM_SHARES_DEF-1:0][BIT_WIDTH_DEF-1:0]  full_sv_t;

endpackage

// File: rtl/join_shared_bv.sv
// Concatenates the hi/lo half registers into the full-width share vector.
// Each share is wired independently; shares never meet.
`timescale 1ns/1ps
module join_shared_bv
  import shared_bv_pkg::*;
#(
  parameter int NUM_SHARES = NUM_SHARES_DEF,
  parameter int HALF_WIDTH = HALF_WIDTH_DEF
) (
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   lo_i,
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   hi_i,
  output logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0] bv_o
);

  // Per-share {hi, lo} concatenation
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    assign bv_o[i] = {hi_i[i], lo_i[i]};
  end

endmodule

// File: rtl/join_shared_bv_seq.sv
// Sequencing controller: collects lo then hi half of a masked bitvector
// over valid/ready and presents the joined word on a registered output.
// Optional build macro JOIN_SEQ_CLEAR_EN zeroes the half registers after
// an output handshake (without a new lo) or a flush.
`timescale 1ns/1ps
module join_shared_bv_seq
  import shared_bv_pkg::*;
#(
  parameter  int NUM_SHARES = NUM_SHARES_DEF,
  parameter  int HALF_WIDTH = HALF_WIDTH_DEF,
  localparam int BIT_WIDTH  = 2 * HALF_WIDTH
) (
  input  logic                                 in_clock,
  input  logic                                 in_reset,
  input  logic                                 in_flush,
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] in_half,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_bv,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  join_state_e                          state_q, state_d;
  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] lo_q, lo_d;
  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] hi_q, hi_d;
  logic                                 xfer;

  // Ready depends only on the held state, out_ready and flush
  assign in_ready  = ~in_flush & ((state_q != FULL) | out_ready);
  assign xfer      = in_valid & in_ready;
  assign out_valid = (state_q == FULL);

  // Next-state and half-register load selection
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (in_flush) begin
      state_d = WAIT_LO;
`ifdef JOIN_SEQ_CLEAR_EN
      lo_d    = '0;
      hi_d    = '0;
`endif
    end else begin
      unique case (state_q)
        WAIT_LO: begin
          if (xfer) begin
            lo_d    = in_half;
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (xfer) begin
            hi_d    = in_half;
            state_d = FULL;
          end
        end
        FULL: begin
          // out_ready implies in_ready here, so xfer is a same-cycle new lo
          if (out_ready) begin
            if (xfer) begin
              lo_d    = in_half;
              state_d = WAIT_HI;
`ifdef JOIN_SEQ_CLEAR_EN
              hi_d    = '0;
`endif
            end else begin
              state_d = WAIT_LO;
`ifdef JOIN_SEQ_CLEAR_EN
              lo_d    = '0;
              hi_d    = '0;
`endif
            end
          end
        end
        default: state_d = WAIT_LO;
      endcase
    end
  end

  // State and half registers; reset discards any partial word at once
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= WAIT_LO;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  join_shared_bv #(
    .NUM_SHARES (NUM_SHARES),
    .HALF_WIDTH (HALF_WIDTH)
  ) u_join (
    .lo_i (lo_q),
    .hi_i (hi_q),
    .bv_o (out_bv)
  );

endmodule

// File: tb/tb_join_shared_bv_seq.sv
// Self-checking bench for join_shared_bv_seq with a word scoreboard.
`timescale 1ns/1ps
module tb_join_shared_bv_seq;
  import shared_bv_pkg::*;

  localparam int NS = 2;
  localparam int HW = 15;
  localparam int BW = 30;

  typedef logic [NS-1:0][HW-1:0] half_t;
  typedef logic [NS-1:0][BW-1:0] word_t;

  logic  clk       = 1'b0;
  logic  rst_n     = 1'b0;
  logic  in_flush  = 1'b0;
  logic  in_valid  = 1'b0;
  logic  out_ready = 1'b0;
  half_t in_half   = '0;
  logic  in_ready;
  logic  out_valid;
  word_t out_bv;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t sb_q[$];
  word_t mon_w;
  int    cnt      = 0;
  half_t lo_m     = '0;
  logic  exp_rdy  = 1'b1;
  logic  exp_vld  = 1'b0;
  int    n_words  = 0;

  always #5 clk = ~clk;

  join_shared_bv_seq #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) dut (
    .in_clock  (clk),
    .in_reset  (rst_n),
    .in_flush  (in_flush),
    .in_half   (in_half),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bv    (out_bv),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Protocol monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_rdy);
      end
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fail++;
        $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_vld);
      end
      if (out_valid && out_ready && !in_flush) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected @%0t: got %h want no word", $time, out_bv);
        end else begin
          mon_w = sb_q.pop_front();
          if (out_bv !== mon_w) begin
            n_fail++;
            $display("FAIL sb_word @%0t: got %h want %h", $time, out_bv, mon_w);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs and advance the reference model
  task automatic cycle(input logic v, input half_t h, input logic ordy, input logic fl);
    word_t w;
    in_valid  = v;
    in_half   = h;
    out_ready = ordy;
    in_flush  = fl;
    exp_vld   = (cnt == 2);
    exp_rdy   = !fl && ((cnt != 2) || ordy);
    if (fl) begin
      if (cnt == 2) sb_q.delete(sb_q.size() - 1);
      cnt = 0;
    end else begin
      if (cnt == 2 && ordy) cnt = 0;
      if (v && exp_rdy) begin
        if (cnt == 0) begin
          lo_m = h;
          cnt  = 1;
        end else begin
          for (int i = 0; i < NS; i++) w[i] = {h[i], lo_m[i]};
          sb_q.push_back(w);
          n_words++;
          cnt = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic half_t rand_half();
    half_t h;
    logic [31:0] r;
    for (int i = 0; i < NS; i++) begin
      r    = $urandom();
      h[i] = r[HW-1:0];
    end
    return h;
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_bv !== '0) begin n_fail++; $display("FAIL reset_bv: got %h want 0", out_bv); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    half_t lo_a, hi_a, lo_b, hi_b;
    lo_a[0] = 15'h1234; lo_a[1] = 15'h0ABC;
    hi_a[0] = 15'h7FFF; hi_a[1] = 15'h0001;
    lo_b[0] = 15'h0555; lo_b[1] = 15'h2AAA;
    hi_b[0] = 15'h0000; hi_b[1] = 15'h7FFE;
    cycle(1'b1, lo_a, 1'b1, 1'b0);
    cycle(1'b1, hi_a, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_lat: got %b want 1", out_valid); end
    n_checks++;
    if (out_bv[0] !== 30'h3FFF9234) begin n_fail++; $display("FAIL stream_s0: got %h want 3fff9234", out_bv[0]); end
    n_checks++;
    if (out_bv[1] !== 30'h00008ABC) begin n_fail++; $display("FAIL stream_s1: got %h want 00008abc", out_bv[1]); end
    cycle(1'b1, lo_b, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap: got %b want 0", out_valid); end
    cycle(1'b1, hi_b, 1'b1, 1'b0);
    n_checks++;
    if (out_bv[1] !== 30'h3FFF2AAA) begin n_fail++; $display("FAIL stream_b_s1: got %h want 3fff2aaa", out_bv[1]); end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    half_t lo, hi, nlo, nhi;
    word_t held;
    lo = rand_half(); hi = rand_half(); nlo = rand_half(); nhi = rand_half();
    for (int i = 0; i < NS; i++) held[i] = {hi[i], lo[i]};
    cycle(1'b1, lo, 1'b1, 1'b0);
    cycle(1'b1, hi, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, nlo, 1'b0, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
      n_checks++;
      if (out_bv !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", k, out_bv, held); end
    end
    cycle(1'b1, nlo, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", out_valid); end
    cycle(1'b1, nhi, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    half_t a, b, junk;
    word_t w;
    a = rand_half(); b = rand_half(); junk = rand_half();
    for (int i = 0; i < NS; i++) w[i] = {b[i], a[i]};
    cycle(1'b1, junk, 1'b1, 1'b0);
    cycle(1'b1, junk, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hi_valid: got %b want 0", out_valid); end
    cycle(1'b1, a, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_half: got %b want 0", out_valid); end
    cycle(1'b1, b, 1'b1, 1'b0);
    n_checks++;
    if (out_bv !== w) begin n_fail++; $display("FAIL flush_relo: got %h want %h", out_bv, w); end
    cycle(1'b1, junk, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", out_valid); end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    half_t x, y;
    x = rand_half(); y = rand_half();
    cycle(1'b1, rand_half(), 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cnt      = 0;
    sb_q.delete();
    exp_rdy  = 1'b1;
    exp_vld  = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_bv !== '0) begin n_fail++; $display("FAIL arst_bv: got %h want 0", out_bv); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", in_ready); end
    cycle(1'b1, x, 1'b1, 1'b0);
    cycle(1'b1, y, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    half_t lo, hi;
    word_t w, exp_w;
    lo = rand_half(); hi = rand_half();
    for (int i = 0; i < NS; i++) w[i] = {hi[i], lo[i]};
`ifdef JOIN_SEQ_CLEAR_EN
    exp_w = '0;
`else
    exp_w = w;
`endif
    cycle(1'b1, lo, 1'b1, 1'b0);
    cycle(1'b1, hi, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_bv !== exp_w) begin n_fail++; $display("FAIL clear_after_hs: got %h want %h", out_bv, exp_w); end
  endtask

  task automatic test_random();
    int guard;
    guard = 0;
    n_words = 0;
    while (n_words < 1000 && guard < 20000) begin
      cycle($urandom_range(0, 3) != 0, rand_half(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
      guard++;
    end
    n_checks++;
    if (n_words < 1000) begin n_fail++; $display("FAIL rand_budget: got %0d words want 1000", n_words); end
    if (cnt == 1) cycle(1'b1, rand_half(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
